// File: rtl/cp0_unit_if.sv
// cp0_unit_if: M-stage signal bundle between the cpu pipeline and the
// coprocessor-0 exception/interrupt unit. The cpu side is the master,
// the cp0 unit is the slave.
interface cp0_unit_if;
  logic [4:0]  A1;
  logic [4:0]  A2;
  logic [31:0] Din;
  logic        WE;
  logic [31:0] PC;
  logic        BDIn;
  logic [4:0]  ExcCodeIn;
  logic        EXLClr;
  logic [5:0]  HWint;
  logic [31:0] Dout;
  logic [31:0] EPCOut;
  logic [31:0] HandlerPC;
  logic        Req;

  modport master (
    output A1, A2, Din, WE, PC, BDIn, ExcCodeIn, EXLClr, HWint,
    input  Dout, EPCOut, HandlerPC, Req
  );

  modport slave (
    input  A1, A2, Din, WE, PC, BDIn, ExcCodeIn, EXLClr, HWint,
    output Dout, EPCOut, HandlerPC, Req
  );
endinterface

// File: rtl/cp0_unit.sv
// cp0_unit: coprocessor-0 exception/interrupt unit sitting in the M stage.
// Holds SR (12), Cause (13) and EPC (14), raises Req for interrupts and
// synchronous exceptions, serves mfc0/mtc0 and clears EXL on eret.
// Optional feature macro: CP0_PRID_EN adds a read-only PRId register (15).
module cp0_unit #(
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180
`ifdef CP0_PRID_EN
  ,
  parameter logic [31:0] PRID_VALUE = 32'h4D49_5053
`endif
) (
  input  logic        clk,
  input  logic        reset,
  cp0_unit_if.slave   bus
);

  // SR fields
  logic [5:0]  im;
  logic        exl;
  logic        ie;
  // Cause fields
  logic        bd;
  logic [5:0]  ip;
  logic [4:0]  exc_code;
  // EPC, always word aligned
  logic [31:0] epc;

  logic        int_req;
  logic        exc_req;
  logic        req;
  logic [31:0] pc_aligned;
  logic [31:0] din_aligned;
  logic [31:0] sr_value;
  logic [31:0] cause_value;
  logic        epc_write;

  // Request decode: pending unmasked interrupt or a synchronous exception,
  // both blocked while already inside a handler.
  always_comb begin
    int_req     = (|(bus.HWint & im)) & ie & ~exl;
    exc_req     = (bus.ExcCodeIn != 5'd0) & ~exl;
    req         = int_req | exc_req;
    pc_aligned  = bus.PC & 32'hFFFF_FFFC;
    din_aligned = bus.Din & 32'hFFFF_FFFC;
    sr_value    = {16'd0, im, 8'd0, exl, ie};
    cause_value = {bd, 15'd0, ip, 3'd0, exc_code, 2'b00};
    epc_write   = bus.WE & ~req & (bus.A2 == 5'd14);
  end

  // Register update: exception entry beats mtc0, eret clears EXL last so an
  // illegal eret+mtc0-to-SR combination leaves EXL cleared.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      im       <= 6'd0;
      exl      <= 1'b0;
      ie       <= 1'b0;
      bd       <= 1'b0;
      ip       <= 6'd0;
      exc_code <= 5'd0;
      epc      <= 32'd0;
    end else begin
      ip <= bus.HWint;
      if (req) begin
        exl      <= 1'b1;
        bd       <= bus.BDIn;
        epc      <= bus.BDIn ? (pc_aligned - 32'd4) : pc_aligned;
        exc_code <= int_req ? 5'd0 : bus.ExcCodeIn;
      end else if (bus.WE) begin
        if (bus.A2 == 5'd12) begin
          im  <= bus.Din[15:10];
          exl <= bus.Din[1];
          ie  <= bus.Din[0];
        end else if (bus.A2 == 5'd14) begin
          epc <= din_aligned;
        end
      end
      if (bus.EXLClr && !req) begin
        exl <= 1'b0;
      end
    end
  end

  // mfc0 read mux returns the pre-edge register contents.
  always_comb begin
    bus.Dout = 32'd0;
    case (bus.A1)
      5'd12:   bus.Dout = sr_value;
      5'd13:   bus.Dout = cause_value;
      5'd14:   bus.Dout = epc;
`ifdef CP0_PRID_EN
      5'd15:   bus.Dout = PRID_VALUE;
`endif
      default: bus.Dout = 32'd0;
    endcase
  end

  // EPC bypass lets an mtc0 EPC directly followed by eret redirect correctly.
  always_comb begin
    bus.EPCOut    = epc_write ? din_aligned : epc;
    bus.HandlerPC = HANDLER_PC;
    bus.Req       = req;
  end

endmodule

// File: tb/tb_cp0_unit.sv
// tb_cp0_unit: table-driven bench for cp0_unit with a scoreboard queue of
// expected combinational outputs, plus hand-written reset sequences.
module tb_cp0_unit;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  cp0_unit_if bus ();

  cp0_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [31:0] din;
    logic        we;
    logic [31:0] pc;
    logic        bd;
    logic [4:0]  exc;
    logic        clr;
    logic [5:0]  hw;
    logic        exp_req;
    logic [31:0] exp_dout;
    logic [31:0] exp_epc;
  } vec_t;

  typedef struct {
    int          idx;
    logic        req;
    logic [31:0] dout;
    logic [31:0] epc;
  } exp_t;

`ifdef CP0_PRID_EN
  localparam logic [31:0] EXP_PRID = 32'h4D49_5053;
`else
  localparam logic [31:0] EXP_PRID = 32'h0000_0000;
`endif

  localparam int NVEC = 20;
  vec_t vecs [NVEC];
  exp_t sb [$];

  function automatic vec_t mk(
    input logic [4:0] a1, input logic we, input logic [4:0] a2,
    input logic [31:0] din, input logic [31:0] pc, input logic bd,
    input logic [4:0] exc, input logic clr, input logic [5:0] hw,
    input logic exp_req, input logic [31:0] exp_dout, input logic [31:0] exp_epc);
    vec_t v;
    v.a1 = a1; v.we = we; v.a2 = a2; v.din = din; v.pc = pc; v.bd = bd;
    v.exc = exc; v.clr = clr; v.hw = hw;
    v.exp_req = exp_req; v.exp_dout = exp_dout; v.exp_epc = exp_epc;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input int idx, input vec_t v);
    exp_t e;
    bus.A1        = v.a1;
    bus.A2        = v.a2;
    bus.Din       = v.din;
    bus.WE        = v.we;
    bus.PC        = v.pc;
    bus.BDIn      = v.bd;
    bus.ExcCodeIn = v.exc;
    bus.EXLClr    = v.clr;
    bus.HWint     = v.hw;
    e.idx  = idx;
    e.req  = v.exp_req;
    e.dout = v.exp_dout;
    e.epc  = v.exp_epc;
    sb.push_back(e);
  endtask

  task automatic checkOutput();
    exp_t e;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("[TB] FAIL scoreboard: empty queue");
      return;
    end
    e = sb.pop_front();
    check($sformatf("row%0d Req", e.idx), {31'd0, bus.Req}, {31'd0, e.req});
    check($sformatf("row%0d Dout", e.idx), bus.Dout, e.dout);
    check($sformatf("row%0d EPCOut", e.idx), bus.EPCOut, e.epc);
  endtask

  task automatic idle_inputs();
    bus.A1 = 5'd0; bus.A2 = 5'd0; bus.Din = 32'd0; bus.WE = 1'b0;
    bus.PC = 32'd0; bus.BDIn = 1'b0; bus.ExcCodeIn = 5'd0;
    bus.EXLClr = 1'b0; bus.HWint = 6'd0;
  endtask

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    total = 0;
    bad   = 0;
    //              a1  we  a2  din           pc            bd  exc clr hw      req dout          epcout
    vecs[0]  = mk(12, 0, 0,  32'h0,        32'h0,        0, 0, 0, 6'h3f, 0, 32'h0,        32'h0);
    vecs[1]  = mk(13, 0, 0,  32'h0,        32'h0,        0, 0, 0, 6'h00, 0, 32'h0000_FC00, 32'h0);
    vecs[2]  = mk(14, 1, 12, 32'h0000_0401, 32'h0,       0, 0, 0, 6'h00, 0, 32'h0,        32'h0);
    vecs[3]  = mk(12, 0, 0,  32'h0,        32'h0000_3010, 0, 0, 0, 6'h01, 1, 32'h0000_0401, 32'h0);
    vecs[4]  = mk(13, 0, 0,  32'h0,        32'h0,        0, 0, 0, 6'h00, 0, 32'h0000_0400, 32'h0000_3010);
    vecs[5]  = mk(12, 0, 0,  32'h0,        32'h0,        0, 0, 1, 6'h00, 0, 32'h0000_0403, 32'h0000_3010);
    vecs[6]  = mk(12, 0, 0,  32'h0,        32'h0000_3024, 1, 4, 0, 6'h00, 1, 32'h0000_0401, 32'h0000_3010);
    vecs[7]  = mk(13, 0, 0,  32'h0,        32'h0,        0, 0, 0, 6'h00, 0, 32'h8000_0010, 32'h0000_3020);
    vecs[8]  = mk(14, 1, 12, 32'h0000_FC03, 32'h0,       0, 0, 0, 6'h04, 0, 32'h0000_3020, 32'h0000_3020);
    vecs[9]  = mk(13, 0, 0,  32'h0,        32'h0,        0, 0, 1, 6'h04, 0, 32'h8000_1010, 32'h0000_3020);
    vecs[10] = mk(12, 1, 14, 32'h0000_3047, 32'h0000_4000, 0, 5, 0, 6'h04, 1, 32'h0000_FC01, 32'h0000_3020);
    vecs[11] = mk(13, 0, 0,  32'h0,        32'h0,        0, 0, 0, 6'h00, 0, 32'h0000_1000, 32'h0000_4000);
    vecs[12] = mk(14, 1, 14, 32'h0000_3047, 32'h0,       0, 0, 0, 6'h00, 0, 32'h0000_4000, 32'h0000_3044);
    vecs[13] = mk(14, 1, 12, 32'h0000_FC03, 32'h0,       0, 0, 1, 6'h00, 0, 32'h0000_3044, 32'h0000_3044);
    vecs[14] = mk(12, 1, 13, 32'hFFFF_FFFF, 32'h0,       0, 0, 0, 6'h00, 0, 32'h0000_FC01, 32'h0000_3044);
    vecs[15] = mk(13, 1, 15, 32'hFFFF_FFFF, 32'h0,       0, 0, 0, 6'h00, 0, 32'h0,        32'h0000_3044);
    vecs[16] = mk(15, 0, 0,  32'h0,        32'h0,        0, 0, 0, 6'h00, 0, EXP_PRID,     32'h0000_3044);
    vecs[17] = mk(20, 0, 0,  32'h0,        32'h0,        0, 0, 0, 6'h00, 0, 32'h0,        32'h0000_3044);
    vecs[18] = mk(12, 1, 12, 32'h0,        32'h0000_5000, 0, 0, 0, 6'h04, 1, 32'h0000_FC01, 32'h0000_3044);
    vecs[19] = mk(12, 0, 0,  32'h0,        32'h0,        0, 0, 0, 6'h04, 0, 32'h0000_FC03, 32'h0000_5000);

    // Reset held: all readable state is zero and no request with IE=0.
    idle_inputs();
    reset = 1'b0;
    bus.HWint = 6'h3f;
    repeat (2) @(negedge clk);
    for (int r = 12; r <= 14; r++) begin
      bus.A1 = 5'(r);
      #1;
      check($sformatf("reset Dout A1=%0d", r), bus.Dout, 32'h0);
    end
    check("reset Req", {31'd0, bus.Req}, 32'h0);
    check("reset EPCOut", bus.EPCOut, 32'h0);
    check("HandlerPC", bus.HandlerPC, 32'h0000_4180);
    idle_inputs();
    @(negedge clk);
    reset = 1'b1;

    // Table sequence: drive on the falling edge, check before the rising edge.
    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      applyStimulus(i, vecs[i]);
      #1;
      checkOutput();
    end

    // Reset dropped between edges while inside a handler clears at once.
    @(negedge clk);
    idle_inputs();
    bus.HWint = 6'h04;
    #2;
    reset = 1'b0;
    for (int r = 12; r <= 14; r++) begin
      bus.A1 = 5'(r);
      #1;
      check($sformatf("midreset Dout A1=%0d", r), bus.Dout, 32'h0);
    end
    check("midreset Req", {31'd0, bus.Req}, 32'h0);
    check("midreset EPCOut", bus.EPCOut, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    bus.A1 = 5'd13;
    #1;
    check("post-reset Cause IP", bus.Dout, 32'h0000_1000);

    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("[TB] FAIL scoreboard: %0d entries left", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cp0_unit.md
Name: cp0_unit

Overview:
- Coprocessor-0 exception/interrupt unit, the consumer of the 6-bit HWint vector assembled at top level ({3'b0, interrupt, IRQ2, IRQ1}).
- Located at the M stage of the cpu; produces `Req`, which drives the cpu's flush and redirect to the handler.
- Holds SR (reg 12), Cause (reg 13) and EPC (reg 14).
- Serves mfc0 reads and mtc0 writes, and clears EXL on eret.

Parameters:
- HANDLER_PC, 32'h0000_4180, handler entry address driven on `HandlerPC`.
- PRID_VALUE, 32'h4D49_5053, PRId contents (used only with CP0_PRID_EN).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low; reset=0 clears all state immediately
- A1  input  5  mfc0 read register number
- A2  input  5  mtc0 write register number
- Din  input  32  mtc0 write data
- WE  input  1  mtc0 write enable (M stage)
- PC  input  32  M-stage PC of the current instruction
- BDIn  input  1  M-stage instruction is in a delay slot
- ExcCodeIn  input  5  M-stage synchronous exception code; 0 = none
- EXLClr  input  1  eret in M stage
- HWint  input  6  hardware interrupt lines, level-sensitive
- Dout  output  32  mfc0 read data (combinational from A1)
- EPCOut  output  32  current EPC, with bypass
- HandlerPC  output  32  constant HANDLER_PC
- Req  output  1  take exception/interrupt this cycle (combinational)

Behaviour:
- SR field layout:
  - IM = SR[15:10]; EXL = SR[1]; IE = SR[0].
  - All other SR bits read 0.
- Cause field layout:
  - BD = [31]; IP = [15:10]; ExcCode = [6:2].
  - All other Cause bits read 0.
- Reset (reset=0, asynchronous):
  - SR, Cause and EPC are all 0.
  - Req=0; EPCOut=0; Dout=0 for every A1.
- IntReq = |(HWint & IM) & IE & ~EXL.
- ExcReq = (ExcCodeIn != 0) & ~EXL.
- Req = IntReq | ExcReq.
- Each rising edge, in priority order:
  1. If Req:
     - EXL<=1.
     - BD<=BDIn.
     - EPC<= BDIn ? {PC[31:2],2'b00}-4 : {PC[31:2],2'b00}.
     - ExcCode<= IntReq ? 5'd0 : ExcCodeIn (interrupt beats synchronous exception).
     - mtc0 in the same cycle is discarded.
  2. Else if WE:
     - A2=12 writes IM, EXL and IE only.
     - A2=14 writes EPC with Din[1:0] forced to 0.
     - A2=13 and all other numbers are ignored; Cause is not software-writable.
  3. If EXLClr and not Req: EXL<=0.
     - EXLClr with EXL=1 cannot coincide with Req, since EXL masks it.
     - EXLClr together with an mtc0 to SR is illegal; if it occurs, EXL ends 0.
- IP<=HWint every cycle, regardless of masks, EXL or Req.
- Dout by A1:
  - 12 → SR
  - 13 → Cause
  - 14 → EPC
  - any other number → 0
- Dout returns the pre-edge register value; there is no same-cycle write-through.
- EPCOut = (WE & ~Req & A2==14) ? {Din[31:2],2'b00} : EPC. This lets an mtc0 EPC immediately followed by eret redirect correctly.
- Req is purely combinational. The cpu must not assert WE/EXLClr effects for a flushed instruction; that is the cpu's responsibility.
- Nested events are blocked while EXL=1:
  - HWint remains visible in IP.
  - Req fires on the first cycle after EXL clears if the condition persists.
- Reset asserted mid-handler aborts everything: EXL=0, EPC=0 asynchronously.

Optional Feature:
- Macro: CP0_PRID_EN.
- When defined:
  - Reg 15 (PRId) reads PRID_VALUE.
  - mtc0 to 15 is ignored.
- When undefined:
  - Reg 15 reads 0, like any unimplemented number.
  - No PRId logic is synthesised.

Test Plan:
1. Reset release, then A1=12,13,14 → Dout=0 each; Req=0 with HWint=6'b111111 (IE=0).
2. mtc0 SR Din=32'h0000_0401 (IM[10]=1, IE=1), then HWint=6'b000001 with PC=32'h0000_3010, BDIn=0 → Req=1 that cycle. Next cycle:
   - EPC=32'h0000_3010.
   - SR=32'h0000_0403.
   - Cause ExcCode=0, IP[10]=1.
   - Req=0.
3. EXL=0, ExcCodeIn=5'd4, PC=32'h0000_3024, BDIn=1 → Req=1. Next cycle:
   - EPC=32'h0000_3020.
   - Cause=32'h8000_0010.
4. With EXL=1:
   - HWint=6'b000100, IM=all 1, IE=1 → Req=0; IP[12]=1.
   - Then EXLClr=1 → next cycle Req=1.
5. Same cycle WE=1, A2=14, Din=32'h0000_3047 → EPCOut=32'h0000_3044 combinationally; EPC=32'h0000_3044 after the edge.
6. Req=1 together with WE=1, A2=12, Din=0 → SR not cleared, EXL=1. Then drop reset to 0 between edges → SR, Cause and EPC read 0 immediately.
   - With CP0_PRID_EN defined: A1=15 → Dout=32'h4D49_5053.
